// File: rtl/symbol_pkg.sv
// ---------------------------------------------------------------------------
// symbol_pkg
// Shared types and constants for the symbol reel sequencer.
//   ROT_W / N_FORMS : width and count of the renderer rotation selector
//   reel_state_t    : sequencer FSM states
//   rot_t           : one reel's form selector
//   LFSR_MASK       : Galois feedback taps of the 16-bit lock-value LFSR
//   lfsr_step()     : one right-shift step of that LFSR
// ---------------------------------------------------------------------------
package symbol_pkg;

    localparam int unsigned ROT_W   = 2;
    localparam int unsigned N_FORMS = 4;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        RESULT
    } reel_state_t;

    typedef logic [ROT_W-1:0] rot_t;

    // Right-shifting Galois step: taps are applied when the bit shifted out is 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/symbol_reel_ctrl_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Galois LFSR supplying pseudo-random reel lock values.
// It shifts on every clock regardless of what the sequencer is doing, so its
// value depends only on the number of cycles since reset.
//   clk : clock
//   rst : synchronous active-high reset, loads SEED
//   q   : current LFSR state
// ---------------------------------------------------------------------------
module lfsr16
    import symbol_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/symbol_reel_ctrl.sv
// ---------------------------------------------------------------------------
// symbol_reel_ctrl
// Slot-machine style sequencer for a row of symbol renderers. On start, all
// reels cycle through the four forms at a frame-locked rate, then lock one by
// one to pseudo-random forms; once the last reel locks, done pulses and win
// reports whether every reel shows the same form.
//   clk        : pixel clock
//   rst        : synchronous active-high reset
//   frame_tick : one-cycle pulse per video frame
//   start      : single-cycle spin request (ignored unless idle)
//   rot_state  : reel k form on bits [2k+1:2k]
//   busy       : spin in progress
//   done       : one-cycle pulse after the last reel locks
//   win        : all reels equal; held until the next accepted start
// ---------------------------------------------------------------------------
module symbol_reel_ctrl
    import symbol_pkg::*;
#(
    parameter int unsigned N_REELS        = 3,
    parameter int unsigned SPIN_FRAMES    = 60,
    parameter int unsigned STAGGER_FRAMES = 20,
    parameter int unsigned STEP_DIV       = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    start,
    output logic [2*N_REELS-1:0]    rot_state,
    output logic                    busy,
    output logic                    done,
    output logic                    win
);

    // Frame counter must reach the last reel's lock tick without wrapping.
    localparam int unsigned FCNT_MAX = SPIN_FRAMES + (N_REELS - 1) * STAGGER_FRAMES;
    localparam int unsigned FCNT_W   = $clog2(FCNT_MAX + 1);
    localparam int unsigned DCNT_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    reel_state_t          state;
    logic [FCNT_W-1:0]    fcnt;
    logic [FCNT_W-1:0]    fcnt_nxt;
    logic [DCNT_W-1:0]    dcnt;
    logic                 dcnt_wrap;
    logic [15:0]          lfsr;
    logic [N_REELS-1:0]   locked;
    logic [N_REELS-1:0]   same;
    logic                 all_locked;
    logic                 accept;
    logic                 spin_tick;
    logic                 step;
    logic                 unused_lfsr_bits;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    // Reels beyond N_REELS leave upper LFSR bits unread.
    assign unused_lfsr_bits = ^lfsr;

    assign all_locked = &locked;
    assign accept     = (state == IDLE) && start;
    // Ticks only count while some reel is still spinning; once all are
    // locked the FSM leaves SPIN on the next edge anyway.
    assign spin_tick  = (state == SPIN) && frame_tick && !all_locked;
    assign fcnt_nxt   = fcnt + FCNT_W'(1);
    assign dcnt_wrap  = (dcnt == DCNT_W'(STEP_DIV - 1));
    assign step       = spin_tick && dcnt_wrap;

    // Sequencer FSM with frame and divider counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= '0;
            dcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            win   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SPIN;
                        busy  <= 1'b1;
                        win   <= 1'b0;
                        fcnt  <= '0;
                        dcnt  <= '0;
                    end
                end
                SPIN: begin
                    if (all_locked) begin
                        state <= RESULT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        win   <= &same;
                    end else if (frame_tick) begin
                        fcnt <= fcnt_nxt;
                        dcnt <= dcnt_wrap ? '0 : dcnt + DCNT_W'(1);
                    end
                end
                RESULT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-reel form register and lock flag.
    for (genvar k = 0; k < N_REELS; k++) begin : g_reel
        localparam int unsigned LOCK_AT = SPIN_FRAMES + k * STAGGER_FRAMES;

        rot_t form;
        logic lk;

        always_ff @(posedge clk) begin
            if (rst) begin
                form <= '0;
                lk   <= 1'b0;
            end else if (accept) begin
                // Forms are held from the previous spin; only the locks clear.
                lk <= 1'b0;
            end else if (spin_tick && (fcnt_nxt == FCNT_W'(LOCK_AT))) begin
                // Lock takes priority over a coincident step.
                form <= lfsr[2*k +: ROT_W];
                lk   <= 1'b1;
            end else if (step && !lk) begin
                form <= (form == ROT_W'(N_FORMS - 1)) ? '0 : form + ROT_W'(1);
            end
        end

        assign rot_state[2*k +: ROT_W] = form;
        assign locked[k]               = lk;
        assign same[k]                 = (form == rot_state[ROT_W-1:0]);
    end

endmodule

// File: tb/tb_symbol_reel_ctrl.sv
// Bench for symbol_reel_ctrl. Three instances share clock, reset, frame_tick
// and start: A (3 reels, divider 1), B (3 reels, divider 3) and C (1 reel,
// which always wins). Expected outputs come from a per-spin event model:
// count frame ticks since the accepted start, derive each reel's form from
// the tick count, and record the reference LFSR value at each lock tick.
module tb_symbol_reel_ctrl;

    localparam int          SPF    = 4;
    localparam int          STG    = 2;
    localparam int          PERIOD = 10;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam int          NI     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_tick = 1'b0;
    logic start = 1'b0;

    logic [5:0] rot_a, rot_b;
    logic [1:0] rot_c;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic win_a, win_b, win_c;

    symbol_reel_ctrl #(.N_REELS(3), .SPIN_FRAMES(SPF), .STAGGER_FRAMES(STG),
                       .STEP_DIV(1), .LFSR_SEED(SEED)) u_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .rot_state(rot_a), .busy(busy_a), .done(done_a), .win(win_a));

    symbol_reel_ctrl #(.N_REELS(3), .SPIN_FRAMES(SPF), .STAGGER_FRAMES(STG),
                       .STEP_DIV(3), .LFSR_SEED(SEED)) u_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .rot_state(rot_b), .busy(busy_b), .done(done_b), .win(win_b));

    symbol_reel_ctrl #(.N_REELS(1), .SPIN_FRAMES(SPF), .STAGGER_FRAMES(STG),
                       .STEP_DIV(1), .LFSR_SEED(SEED)) u_c (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .rot_state(rot_c), .busy(busy_c), .done(done_c), .win(win_c));

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int phase = 0;
    logic [15:0] lfsr_m;

    // Reference model state per instance.
    bit act_m [NI];
    int n_m [NI];
    int post_m [NI];
    bit win_m [NI];
    int base_m [NI][3];
    int lv_m [NI][3];

    logic [5:0] exp_rot [NI];
    logic [5:0] act_rot [NI];
    logic exp_busy [NI], act_busy [NI];
    logic exp_done [NI], act_done [NI];
    logic exp_win [NI], act_win [NI];

    function automatic int nr(input int i);
        return (i == 2) ? 1 : 3;
    endfunction

    function automatic int dv(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    function automatic int lock_at(input int k);
        return SPF + k * STG;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Advance the model by one clock edge for every instance.
    task automatic model_edge(input bit st, input bit tk, input bit rs, input logic [15:0] lp);
        for (int i = 0; i < NI; i++) begin
            if (rs) begin
                act_m[i] = 0; win_m[i] = 0; n_m[i] = 0; post_m[i] = -1;
                for (int k = 0; k < 3; k++) begin base_m[i][k] = 0; lv_m[i][k] = 0; end
            end else if (!act_m[i]) begin
                if (st) begin
                    act_m[i] = 1; n_m[i] = 0; post_m[i] = -1; win_m[i] = 0;
                end
            end else if (post_m[i] < 0) begin
                if (tk) begin
                    n_m[i]++;
                    for (int k = 0; k < nr(i); k++)
                        if (n_m[i] == lock_at(k)) lv_m[i][k] = int'((lp >> (2 * k)) & 16'h0003);
                    if (n_m[i] == lock_at(nr(i) - 1)) post_m[i] = 0;
                end
            end else begin
                post_m[i]++;
                if (post_m[i] == 1) begin
                    win_m[i] = 1;
                    for (int k = 0; k < nr(i); k++)
                        if (lv_m[i][k] != lv_m[i][0]) win_m[i] = 0;
                end
                if (post_m[i] == 2) begin
                    act_m[i] = 0;
                    for (int k = 0; k < 3; k++) base_m[i][k] = lv_m[i][k];
                end
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, step the model across the
    // rising edge, and capture expected/actual outputs at the next falling edge.
    task automatic adv(input bit st, input bit rs);
        logic [15:0] lp;
        bit tk;
        logic [5:0] e;
        int f;
        start = st;
        rst = rs;
        frame_tick = (phase == PERIOD - 1);
        tk = frame_tick;
        lp = lfsr_m;
        @(negedge clk);
        phase = (phase + 1) % PERIOD;
        lfsr_m = rs ? SEED : lfsr_next(lfsr_m);
        model_edge(st, tk, rs, lp);
        for (int i = 0; i < NI; i++) begin
            e = '0;
            for (int k = 0; k < nr(i); k++) begin
                if (!act_m[i]) f = base_m[i][k];
                else if (n_m[i] < lock_at(k)) f = (base_m[i][k] + n_m[i] / dv(i)) % 4;
                else f = lv_m[i][k];
                e[2*k +: 2] = 2'(f);
            end
            exp_rot[i]  = e;
            exp_busy[i] = act_m[i] && (post_m[i] < 1);
            exp_done[i] = act_m[i] && (post_m[i] == 1);
            exp_win[i]  = win_m[i];
        end
        act_rot[0] = rot_a; act_rot[1] = rot_b; act_rot[2] = {4'b0000, rot_c};
        act_busy[0] = busy_a; act_busy[1] = busy_b; act_busy[2] = busy_c;
        act_done[0] = done_a; act_done[1] = done_b; act_done[2] = done_c;
        act_win[0] = win_a; act_win[1] = win_b; act_win[2] = win_c;
    endtask

    // Start a spin and follow it to completion, comparing every cycle.
    // ign_tick: extra start pulse after that tick of instance A.
    // rst_tick: reset after that tick of instance A. rnd: random extra starts.
    task automatic run_spin(input string tag, input int ign_tick, input int rst_tick,
                            input bit rnd, output int done_cnt);
        bit ign_done;
        bit st, rs, any;
        int cyc;
        ign_done = 0;
        done_cnt = 0;
        adv(1, 0);
        any = 1;
        cyc = 0;
        while (any && cyc < 400) begin
            checks += 4 * NI;
            for (int i = 0; i < NI; i++) begin
                if (act_rot[i] !== exp_rot[i]) begin failures++;
                    $display("FAIL %s rot[%0d] got=%b exp=%b t=%0t", tag, i, act_rot[i], exp_rot[i], $time); end
                if (act_busy[i] !== exp_busy[i]) begin failures++;
                    $display("FAIL %s busy[%0d] got=%b exp=%b t=%0t", tag, i, act_busy[i], exp_busy[i], $time); end
                if (act_done[i] !== exp_done[i]) begin failures++;
                    $display("FAIL %s done[%0d] got=%b exp=%b t=%0t", tag, i, act_done[i], exp_done[i], $time); end
                if (act_win[i] !== exp_win[i]) begin failures++;
                    $display("FAIL %s win[%0d] got=%b exp=%b t=%0t", tag, i, act_win[i], exp_win[i], $time); end
            end
            if (act_done[0] === 1'b1) done_cnt++;
            any = act_m[0] || act_m[1] || act_m[2];
            if (any) begin
                st = 0;
                rs = 0;
                if (ign_tick > 0 && n_m[0] == ign_tick && !ign_done) begin st = 1; ign_done = 1; end
                if (rnd && act_m[0] && post_m[0] < 0 && $urandom_range(0, 19) == 0) st = 1;
                if (rst_tick > 0 && act_m[0] && n_m[0] == rst_tick) begin rs = 1; st = 0; end
                adv(st, rs);
                cyc++;
            end
        end
        if (any) begin
            checks++; failures++;
            $display("FAIL %s timeout waiting for spin end got=busy exp=idle", tag);
        end
    endtask

    task automatic test_reset();
        repeat (3) adv(0, 1);
        checks++;
        if (u_a.u_lfsr.q !== SEED) begin failures++;
            $display("FAIL reset lfsr got=%h exp=%h", u_a.u_lfsr.q, SEED); end
        for (int i = 0; i < NI; i++) begin
            checks += 4;
            if (act_rot[i] !== 6'b0) begin failures++;
                $display("FAIL reset rot[%0d] got=%b exp=0", i, act_rot[i]); end
            if (act_busy[i] !== 1'b0) begin failures++;
                $display("FAIL reset busy[%0d] got=%b exp=0", i, act_busy[i]); end
            if (act_done[i] !== 1'b0) begin failures++;
                $display("FAIL reset done[%0d] got=%b exp=0", i, act_done[i]); end
            if (act_win[i] !== 1'b0) begin failures++;
                $display("FAIL reset win[%0d] got=%b exp=0", i, act_win[i]); end
        end
        adv(0, 0);
    endtask

    task automatic test_normal_spin();
        int dc;
        repeat ($urandom_range(0, 30)) adv(0, 0);
        run_spin("normal", 0, 0, 0, dc);
        checks++;
        if (dc != 1) begin failures++;
            $display("FAIL normal done_pulses got=%0d exp=1", dc); end
    endtask

    task automatic test_win_hold();
        int dc;
        // A single reel always matches itself; win must hold through idle.
        for (int c = 0; c < 12; c++) begin
            adv(0, 0);
            checks++;
            if (act_win[2] !== 1'b1) begin failures++;
                $display("FAIL win_hold win_c got=%b exp=1", act_win[2]); end
        end
        run_spin("win_clear", 0, 0, 0, dc);
        checks++;
        if (act_win[2] !== 1'b1) begin failures++;
            $display("FAIL win_after win_c got=%b exp=1", act_win[2]); end
    endtask

    task automatic test_ignored_start();
        int dc;
        run_spin("ignored_start", 2, 0, 0, dc);
        checks++;
        if (dc != 1) begin failures++;
            $display("FAIL ignored_start done_pulses got=%0d exp=1", dc); end
    endtask

    task automatic test_reset_mid_spin();
        int dc;
        run_spin("reset_mid", 0, 5, 0, dc);
        checks++;
        if (dc != 0) begin failures++;
            $display("FAIL reset_mid done_pulses got=%0d exp=0", dc); end
        adv(0, 1);
        for (int c = 0; c < 25; c++) begin
            adv(0, 0);
            checks += 3;
            if (done_a !== 1'b0 || done_b !== 1'b0 || done_c !== 1'b0) begin failures++;
                $display("FAIL reset_mid done got=%b%b%b exp=000", done_a, done_b, done_c); end
            if (rot_a !== 6'b0 || rot_b !== 6'b0 || rot_c !== 2'b0) begin failures++;
                $display("FAIL reset_mid rot got=%b/%b/%b exp=0", rot_a, rot_b, rot_c); end
            if (busy_a !== 1'b0) begin failures++;
                $display("FAIL reset_mid busy_a got=%b exp=0", busy_a); end
        end
        run_spin("after_reset", 0, 0, 0, dc);
        checks++;
        if (dc != 1) begin failures++;
            $display("FAIL after_reset done_pulses got=%0d exp=1", dc); end
    endtask

    task automatic test_back_to_back();
        int dc1, dc2;
        run_spin("b2b_first", 0, 0, 0, dc1);
        // The next start lands in the first idle cycle after the done pulse.
        run_spin("b2b_second", 0, 0, 0, dc2);
        checks++;
        if (dc1 != 1 || dc2 != 1) begin failures++;
            $display("FAIL b2b done_pulses got=%0d,%0d exp=1,1", dc1, dc2); end
    endtask

    task automatic test_random();
        int dc;
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 40)) adv(0, 0);
            run_spin("random", 0, 0, 1, dc);
            checks++;
            if (dc != 1) begin failures++;
                $display("FAIL random done_pulses got=%0d exp=1", dc); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_normal_spin();
        test_win_hold();
        test_ignored_start();
        test_reset_mid_spin();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/symbol_reel_ctrl.md
# symbol_reel_ctrl

Sequencer that drives the `rot_state` selectors of a row of on-screen symbol renderers. It animates them like slot-machine reels: all reels cycle through the four symbol forms at a frame-locked rate, then lock one after another to pseudo-random final forms, and finally report whether all reels match. It sits between the game-control logic (start request) and the VGA symbol renderers, and is clocked in the pixel-clock domain using the frame-start pulse from the VGA timing generator.

## Interface

Parameters:
- `N_REELS`, 3: number of symbol instances driven (1..8).
- `SPIN_FRAMES`, 60: frame ticks after start before reel 0 locks (≥1).
- `STAGGER_FRAMES`, 20: additional frame ticks between successive reel locks (≥1).
- `STEP_DIV`, 4: frame ticks per symbol step while spinning (≥1).
- `LFSR_SEED`, 16'hACE1: LFSR reset value (must be nonzero).

Ports:
- `clk`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `start`, in, 1: single-cycle spin request.
- `rot_state`, out, 2*N_REELS: reel k drives bits [2k+1:2k] to its renderer.
- `busy`, out, 1: high while a spin is in progress.
- `done`, out, 1: one-cycle pulse when the last reel locks.
- `win`, out, 1: all reels show the same form; held until the next start.

## Operation

- Reset values: state IDLE, `rot_state`=0, `busy`=0, `done`=0, `win`=0, LFSR=`LFSR_SEED`, all counters 0.
- FSM states:
  - IDLE: `rot_state` held. A `start` pulse moves the FSM to SPIN. On that transition, clear `win`, the frame counter `fcnt`, the divider `dcnt` and all `locked[k]` flags.
  - SPIN: runs the reels as described in the bullets below.
  - RESULT: lasts one cycle. `done`=1, `busy`=0, `win` is registered. Then the FSM returns to IDLE.
- Behaviour on each `frame_tick` in SPIN:
  - `fcnt` increments. Width is sufficient for SPIN_FRAMES+(N_REELS-1)*STAGGER_FRAMES with no wrap.
  - `dcnt` increments and wraps to 0 at STEP_DIV-1.
  - On the wrap, every unlocked reel advances its form 0→1→2→3→0 (mod-4 wrap).
- Reel lock:
  - Reel k locks on the frame_tick where the post-increment `fcnt` equals SPIN_FRAMES+k*STAGGER_FRAMES.
  - At lock, the reel loads `lfsr[2k+1:2k]` (LFSR value before that cycle's shift) and sets `locked[k]`.
  - If a lock and a step fall on the same tick for the same reel, the lock wins.
- Transition to RESULT happens on the cycle after reel N_REELS-1 locks. `win` = AND over all k of (reel k == reel 0).
- `start` while `busy`=1 or in RESULT is ignored; no queuing.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every clk regardless of state. Its value is therefore a function of cycle count since reset.
- `rst` asserted mid-spin: every register returns to its reset value on that edge. No `done` pulse is produced.
- `frame_tick` in IDLE or RESULT is ignored.

## Timing

- Start latency: `start` high at edge t gives `busy`=1 from t+1. The first frame_tick counted is the first one sampled at or after edge t+1.
- Outputs: all registered; `rot_state` changes only on edges where `frame_tick` was 1 (or at reset).
- Reel k lock: the locked value is visible on `rot_state` on the cycle after the qualifying frame_tick edge.
- Completion: `done` and `busy`=0 appear one cycle after the last lock becomes visible. `done` is exactly one cycle wide.
- Spin duration: SPIN_FRAMES+(N_REELS-1)*STAGGER_FRAMES frame ticks plus 2 clk.
- Back-to-back spins: a `start` in the cycle after `done` (state IDLE) is accepted.

## Structure

- Package `symbol_pkg`:
  - `ROT_W`=2 and `N_FORMS`=4.
  - `typedef enum logic [1:0] {IDLE, SPIN, RESULT} reel_state_t`.
  - `typedef logic [ROT_W-1:0] rot_t`.
  - LFSR mask constant.
- Sub-module `lfsr16`: inputs `clk`, `rst`; parameter `SEED`; output `q[15:0]`. Shifts every cycle.
- Main module: FSM, `fcnt`/`dcnt`, per-reel form registers and `locked` vector, all in a generate loop over N_REELS.

## Test plan

Default bench parameters: N_REELS=3, SPIN_FRAMES=4, STAGGER_FRAMES=2, STEP_DIV=1, frame_tick every 10 clk.

- Reset: hold `rst` 3 clk, release → `rot_state`=6'b0, `busy`=0, `done`=0, `win`=0, LFSR=16'hACE1.
- Normal spin: pulse `start` →
  - `busy`=1 next cycle;
  - all reels step 0→1→2→3 on ticks 1–3;
  - reel 0 locks at tick 4 to `lfsr[1:0]`, reel 1 at tick 6, reel 2 at tick 8, each locked value matching a reference-model LFSR;
  - `done`=1 for exactly one cycle one cycle after the tick-8 update.
- Win detect: force the LFSR model to a seed yielding equal 2-bit fields at lock cycles (or use N_REELS=1) → `win`=1, held through IDLE until the next `start`, then cleared.
- Ignored start: pulse `start` at tick 2 of a spin → no restart; lock ticks remain 4/6/8.
- Reset mid-spin: assert `rst` at tick 5 → `rot_state`=0, `busy`=0, no `done`. A subsequent `start` gives a full, correct spin.
- Divider: set STEP_DIV=3 → unlocked reels advance only on ticks 3, 6, …. A tick coinciding with a lock loads the LFSR value, not value+1.
